// File: rtl/icache_pkg.sv
// Shared types for the parametrised instruction cache: FSM states and
// default-geometry field widths.
package icache_pkg;

  typedef enum logic [1:0] {
    RSET = 2'd0,
    IDLE = 2'd1,
    REQ  = 2'd2,
    WRIT = 2'd3
  } state_e;

  localparam int DEF_WAYS       = 4;
  localparam int DEF_SETS       = 128;
  localparam int DEF_LINE_WORDS = 8;
  localparam int DEF_ADDR_W     = 32;

  localparam int IDX_W = $clog2(DEF_SETS);
  localparam int OFF_W = $clog2(DEF_LINE_WORDS) + 2;
  localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             valid;
  } tagv_t;

endpackage

// File: rtl/icache_plru.sv
// Tree pseudo-LRU helper: victim walk and access update for one set.
// Node n has children 2n+1 (left) and 2n+2 (right); bit 0 means victim is left.
module icache_plru #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         tree_i,
  input  logic [$clog2(WAYS)-1:0] way_i,
  input  logic                    en_i,
  output logic [WAYS-2:0]         tree_o,
  output logic [$clog2(WAYS)-1:0] victim_o
);

  localparam int WAY_W = $clog2(WAYS);

  always_comb begin
    int node_v;
    victim_o = '0;
    node_v   = 0;
    for (int l = 0; l < WAY_W; l++) begin
      victim_o[WAY_W-1-l] = tree_i[node_v];
      node_v = 2 * node_v + 1 + int'(tree_i[node_v]);
    end
  end

  // Every node on the accessed path is turned to point at the other subtree.
  always_comb begin
    int node_u;
    tree_o = tree_i;
    node_u = 0;
    if (en_i) begin
      for (int l = 0; l < WAY_W; l++) begin
        tree_o[node_u] = ~way_i[WAY_W-1-l];
        node_u = 2 * node_u + 1 + int'(way_i[WAY_W-1-l]);
      end
    end
  end

endmodule

// File: rtl/icache_param.sv
// Parametrised set-associative instruction cache with tree-PLRU replacement,
// whole-line refill and a software invalidate-all sweep.
module icache_param
  import icache_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     rd_req,
  output logic                     miss,
  output logic [31:0]              rd_data,
  input  logic                     inv_req,
  output logic                     inv_done,
  output logic [ADDR_W-1:0]        icache_addr,
  output logic                     icache_rd_req,
  input  logic                     icache_gnt,
  input  logic [32*LINE_WORDS-1:0] icache_data
);

  localparam int SET_W      = $clog2(SETS);
  localparam int WORD_OFF_W = $clog2(LINE_WORDS);
  localparam int BYTE_OFF_W = WORD_OFF_W + 2;
  localparam int LINE_TAG_W = ADDR_W - SET_W - BYTE_OFF_W;
  localparam int WAY_W      = $clog2(WAYS);
  localparam int LINE_W     = 32 * LINE_WORDS;

  typedef struct packed {
    logic [LINE_TAG_W-1:0] tag;
    logic                  valid;
  } way_tagv_t;

  state_e                        state_q, state_d;
  logic [SET_W-1:0]              cnt_q, cnt_d;
  logic [SET_W-1:0]              index_q;
  logic [SET_W-1:0]              rd_idx;
  logic [SET_W-1:0]              set_idx;
  logic                          pend_q, pend_d;
  logic                          from_inv_q, from_inv_d;
  logic [LINE_W-1:0]             line_q;
  logic [LINE_TAG_W-1:0]         tag_in;
  logic [WORD_OFF_W-1:0]         word_sel;
  logic                          ram_ready;
  logic                          hit;
  logic [WAYS-1:0]               way_valid;
  logic [WAYS-1:0]               way_match;
  logic [WAYS-1:0][LINE_TAG_W-1:0] way_tag;
  logic [WAYS-1:0][LINE_W-1:0]   way_line;
  logic [WAY_W-1:0]              hit_way;
  logic [WAY_W-1:0]              victim;
  logic [WAY_W-1:0]              plru_victim;
  logic [WAY_W-1:0]              plru_way;
  logic [WAYS-2:0]               plru_q [SETS];
  logic [WAYS-2:0]               plru_cur;
  logic [WAYS-2:0]               plru_next;
  logic                          plru_we;
  logic [WAYS-1:0]               tag_we;
  logic [WAYS-1:0]               data_we;
  way_tagv_t                     tag_wdata;
  logic                          unused_addr_bits;

  assign set_idx          = addr[BYTE_OFF_W +: SET_W];
  assign tag_in           = addr[ADDR_W-1 -: LINE_TAG_W];
  assign word_sel         = addr[2 +: WORD_OFF_W];
  assign unused_addr_bits = ^addr[1:0];

  // The sweep counter owns the array port in RSET; the fetch index otherwise.
  assign rd_idx    = (state_q == RSET) ? cnt_q : set_idx;
  assign ram_ready = (rd_idx == index_q);

  // Write port shares the read index, so a write is visible on the next read.
  always_comb begin
    tag_we    = '0;
    data_we   = '0;
    tag_wdata = '0;
    if (!rst) begin
      if (state_q == RSET) begin
        tag_we = '1;
      end else if (state_q == WRIT) begin
        tag_we[victim]  = 1'b1;
        data_we[victim] = 1'b1;
        tag_wdata.tag   = tag_in;
        tag_wdata.valid = 1'b1;
      end
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    way_tagv_t         tagv_mem [SETS];
    logic [LINE_W-1:0] data_mem [SETS];
    way_tagv_t         tagv_rd_q;
    logic [LINE_W-1:0] data_rd_q;

    always_ff @(posedge clk) begin
      if (tag_we[w]) begin
        tagv_mem[rd_idx] <= tag_wdata;
      end
      if (rst) begin
        tagv_rd_q <= '0;
      end else if (tag_we[w]) begin
        tagv_rd_q <= tag_wdata;
      end else begin
        tagv_rd_q <= tagv_mem[rd_idx];
      end
    end

    always_ff @(posedge clk) begin
      if (data_we[w]) begin
        data_mem[rd_idx] <= line_q;
        data_rd_q        <= line_q;
      end else begin
        data_rd_q <= data_mem[rd_idx];
      end
    end

    assign way_valid[w] = tagv_rd_q.valid;
    assign way_tag[w]   = tagv_rd_q.tag;
    assign way_line[w]  = data_rd_q;
  end

  // Lowest matching way wins the hit; lowest invalid way is preferred as victim.
  always_comb begin
    way_match = '0;
    hit_way   = '0;
    victim    = plru_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      way_match[w] = way_valid[w] && (way_tag[w] == tag_in);
      if (way_match[w]) begin
        hit_way = WAY_W'(w);
      end
      if (!way_valid[w]) begin
        victim = WAY_W'(w);
      end
    end
  end

  assign hit     = ram_ready & (|way_match);
  assign rd_data = hit ? way_line[hit_way][32*word_sel +: 32] : 32'h0;
  assign miss    = rst | (state_q != IDLE) | (rd_req & ~hit);

  assign icache_addr = {addr[ADDR_W-1:BYTE_OFF_W], {BYTE_OFF_W{1'b0}}};

  assign plru_cur = plru_q[set_idx];
  assign plru_way = (state_q == WRIT) ? victim : hit_way;
  assign plru_we  = ~rst & ((state_q == WRIT) | ((state_q == IDLE) & rd_req & hit));

  icache_plru #(
    .WAYS(WAYS)
  ) u_plru (
    .tree_i  (plru_cur),
    .way_i   (plru_way),
    .en_i    (plru_we),
    .tree_o  (plru_next),
    .victim_o(plru_victim)
  );

  always_ff @(posedge clk) begin
    if (state_q == RSET) begin
      plru_q[cnt_q] <= '0;
    end else if (plru_we) begin
      plru_q[set_idx] <= plru_next;
    end
  end

  // Refill handshake: icache_rd_req stays high from the request cycle until
  // icache_gnt is seen in REQ; the whole line transfers in that single cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q | inv_req;
    from_inv_d    = from_inv_q;
    icache_rd_req = 1'b0;
    inv_done      = 1'b0;
    case (state_q)
      RSET: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SET_W'(SETS - 1)) begin
          state_d    = IDLE;
          inv_done   = from_inv_q;
          from_inv_d = 1'b0;
        end
      end
      IDLE: begin
        if (pend_q | inv_req) begin
          state_d    = RSET;
          cnt_d      = '0;
          pend_d     = 1'b0;
          from_inv_d = 1'b1;
        end else if (rd_req & ram_ready & ~hit) begin
          state_d       = REQ;
          icache_rd_req = 1'b1;
        end
      end
      REQ: begin
        icache_rd_req = 1'b1;
        if (icache_gnt) begin
          state_d = WRIT;
        end
      end
      WRIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = RSET;
      end
    endcase
    if (rst) begin
      icache_rd_req = 1'b0;
      inv_done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    index_q <= rd_idx;
    if (rst) begin
      state_q    <= RSET;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      from_inv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      from_inv_q <= from_inv_d;
    end
    if (!rst && state_q == REQ && icache_gnt) begin
      line_q <= icache_data;
    end
  end

endmodule

// File: doc/icache_param.md
Name: icache_param

Overview:
- Parametrised set-associative instruction cache in the IF stage. It is the next-generation replacement for the fixed 4-way/128-set/8-word icache.
- Keeps the same CPU-side stall interface (`miss`) and the same AXI-side whole-line refill handshake.
- New relative to the fixed design:
  - configurable geometry;
  - tree pseudo-LRU replacement;
  - invalid-way-first victim selection;
  - software-triggered invalidate-all (`inv_req`/`inv_done`), used by cache ops and self-modifying code.

Parameters:
- WAYS, 4, number of ways; power of 2, range 2..8.
- SETS, 128, number of sets; power of 2. IDX_W = log2(SETS).
- LINE_WORDS, 8, 32-bit words per line; power of 2. OFF_W = log2(LINE_WORDS)+2.
- ADDR_W, 32, address width. TAG_W = ADDR_W-IDX_W-OFF_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- addr  in  ADDR_W  fetch address; must be held stable while miss=1
- rd_req  in  1  fetch request
- miss  out  1  stall to CPU; rd_data is valid when rd_req=1 and miss=0
- rd_data  out  32  fetched word
- inv_req  in  1  level request to invalidate every line
- inv_done  out  1  one-cycle pulse when invalidation completes
- icache_addr  out  ADDR_W  line-aligned refill address: {addr[ADDR_W-1:OFF_W], OFF_W'b0}
- icache_rd_req  out  1  refill request to the AXI module
- icache_gnt  in  1  refill line valid on icache_data this cycle
- icache_data  in  32*LINE_WORDS  refill line; word k at bits [32k+31:32k]

Behaviour:
- Storage:
  - tag+valid array and data array per way, SETS entries each.
  - Synchronous read, addressed by the current index (the sweep counter in RSET). Write-first.
  - plru array: SETS x (WAYS-1) bits, in flops.
- ram_ready: index_q <= index every cycle. ram_ready = (index == index_q). hit = ram_ready & any way valid with tag match.
- Outputs:
  - miss = rst | state!=IDLE | (rd_req & ~hit).
  - rd_data = hitting way's word at addr[OFF_W-1:2]; 0 when there is no hit.
- States and transitions:
  - RSET: sweep counter 0..SETS-1. Writes valid=0 to all ways at the counter index, one set per cycle. Clears plru at the same index. After the last set goes to IDLE, pulsing inv_done if the sweep was entered via inv_req.
  - IDLE, priority order:
    - pending inv_req → RSET (counter 0);
    - else rd_req & ram_ready & ~hit → REQ, with icache_rd_req=1 already in this cycle;
    - else stay in IDLE.
  - REQ: icache_rd_req=1. On icache_gnt → WRIT, capturing icache_data into a line register.
  - WRIT:
    - Writes the line register, tag, and valid=1 into the victim way at the index.
    - Sets plru to make that way MRU.
    - Next state is IDLE.
    - Because arrays are write-first, the first IDLE cycle after WRIT hits. Refill-to-hit latency is 1 cycle.
- Victim selection (evaluated in WRIT):
  - lowest-numbered invalid way, if any;
  - else the tree-PLRU victim. Node bit 0 = victim in the left subtree; bit 1 = right.
- PLRU update: on every IDLE hit (counted once per cycle), each node on the path to the accessed way points away from it.
- inv_req handling:
  - Latched into a pending flag in any state.
  - Serviced only from IDLE, so an in-flight refill completes first.
  - The pending flag clears on RSET entry.
- rst in any state:
  - → RSET, counter=0, pending flag=0.
  - icache_rd_req=0 and inv_done=0 during rst.
  - An abandoned refill's later gnt is ignored outside REQ.
- Reset values of outputs: miss=1, icache_rd_req=0, inv_done=0, rd_data=0.
- Simultaneous inv_req with a miss in IDLE: invalidate wins and no refill is started. The miss is re-detected after the sweep.

Decomposition:
- icache_pkg:
  - state enum {RSET, IDLE, REQ, WRIT};
  - clog2-derived width localparams (IDX_W, OFF_W, TAG_W);
  - a tagv struct {tag, valid}.
- Sub-module icache_plru: combinational, parametrised by WAYS. Inputs: current tree bits, access way, access enable. Outputs: next tree bits, victim way.

Test Plan:
- Reset: rst high 2 cycles then low → miss=1 for exactly SETS=128 cycles, icache_rd_req=0 throughout, inv_done stays 0.
- Cold miss: rd_req, addr=0x0000_1024 → icache_rd_req=1 and icache_addr=0x0000_1020 in the same cycle. gnt after 5 cycles with word k = 0xA000_000k → one WRIT cycle, then next IDLE cycle miss=0, rd_data=0xA000_0001.
- Replacement (WAYS=4): fill set 5 with tags A, B, C, D (ways 0–3), re-hit A, then miss on tag E.
  - Required: E fills way 2, evicting C.
  - Re-reading A, B, D hits; reading C misses.
- Invalidate: warm 3 lines, assert inv_req → 128-cycle sweep, inv_done one-cycle pulse, then all 3 addresses miss.
- inv_req during REQ → refill completes (WRIT), then sweep runs; the line just written is invalid afterwards.
- rst asserted mid-REQ: icache_rd_req drops in the same cycle. A gnt arriving 2 cycles later causes no array write. Post-sweep reads miss.
